// File: rtl/reg_wb_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_sched_pkg
//  Description : Shared defaults and requester index constants for the
//                write-back scheduler / scoreboard slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_wb_sched_pkg;

    localparam int NREQ_DEF = 3;               // write-back requesters
    localparam int AW_DEF   = 6;               // register address width
    localparam int DW_DEF   = 32;              // register data width
    localparam int NREGS    = 1 << AW_DEF;     // 64 architectural registers

    // Fixed requester slots on the write-back bus
    localparam int REQ_ALU  = 0;
    localparam int REQ_FPU  = 1;
    localparam int REQ_LOAD = 2;

endpackage
`default_nettype wire

// File: rtl/reg_wb_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_sched_if
//  Description : Bundle of the requester handshake, allocation, hazard query
//                and register-file write signals of the write-back scheduler.
//                master : producers / issue stage side (drives requests)
//                slave  : scheduler side (drives grants, hazards, rf write)
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_wb_sched_if
    import reg_wb_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               alloc_valid;
    logic [AW-1:0]      alloc_addr;
    logic               alloc_ready;
    logic [AW-1:0]      ra1;
    logic [AW-1:0]      ra2;
    logic               hazard1;
    logic               hazard2;
    logic               rf_we;
    logic [AW-1:0]      rf_wa;
    logic [DW-1:0]      rf_wd;

    modport master (
        output req_valid, req_addr, req_data, alloc_valid, alloc_addr, ra1, ra2,
        input  req_ready, alloc_ready, hazard1, hazard2, rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  req_valid, req_addr, req_data, alloc_valid, alloc_addr, ra1, ra2,
        output req_ready, alloc_ready, hazard1, hazard2, rf_we, rf_wa, rf_wd
    );
endinterface
`default_nettype wire

// File: rtl/reg_wb_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_sched_rr_arbiter
//  Description : Combinational round-robin arbiter. Searches valid_i starting
//                at ptr_i+1 (mod NREQ) and grants the first valid requester.
//  Ports       : valid_i [NREQ] request vector
//                ptr_i   [PW]   index of the last granted requester
//                grant_o [NREQ] one-hot grant, zero when nothing is valid
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_sched_rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  wire logic [NREQ-1:0] valid_i,
    input  wire logic [PW-1:0]   ptr_i,
    output logic      [NREQ-1:0] grant_o
);

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        // k runs 1..NREQ so the last granted requester is checked last
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr_i) + k) % NREQ);
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_sched
//  Description : Write-back scheduler and RAW scoreboard for the 64x32
//                2R/1W register file. Round-robin shares the write port among
//                NREQ producers, registers the selected write, and tracks
//                pending destinations for issue-stage hazard detection.
//  Ports       : clk, rst_n (async, active low)
//                bus : reg_wb_sched_if.slave (requests, allocation, hazard
//                      query, registered register-file write)
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_sched
    import reg_wb_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    reg_wb_sched_if.slave bus
);

    localparam int PW = $clog2(NREQ);
    localparam int NR = 1 << AW;

    logic [NR-1:0]   pending_q, pending_d;
    logic [PW-1:0]   rr_ptr_q,  rr_ptr_d;
    logic            rf_we_q,   rf_we_d;
    logic [AW-1:0]   rf_wa_q,   rf_wa_d;
    logic [DW-1:0]   rf_wd_q,   rf_wd_d;

    logic [NREQ-1:0] grant;
    logic            alloc_ok;

    reg_wb_sched_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .valid_i (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    // The write in flight makes its register readable through the RF bypass
    // and frees it for a new owner, so it masks both pending checks.
    assign alloc_ok        = ~pending_q[bus.alloc_addr] | (rf_we_q & (rf_wa_q == bus.alloc_addr));
    assign bus.alloc_ready = alloc_ok;
    assign bus.hazard1     = pending_q[bus.ra1] & ~(rf_we_q & (rf_wa_q == bus.ra1));
    assign bus.hazard2     = pending_q[bus.ra2] & ~(rf_we_q & (rf_wa_q == bus.ra2));
    assign bus.req_ready   = grant;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_wa       = rf_wa_q;
    assign bus.rf_wd       = rf_wd_q;

    always_comb begin
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        rr_ptr_d  = rr_ptr_q;
        // grant is only ever raised on a valid requester, so grant[i] is a transfer
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                rf_we_d  = 1'b1;
                rf_wa_d  = bus.req_addr[i*AW +: AW];
                rf_wd_d  = bus.req_data[i*DW +: DW];
                rr_ptr_d = PW'(i);
            end
        end

        // Clear first, then set: a new allocation on the write edge keeps the bit
        pending_d = pending_q;
        if (rf_we_q) begin
            pending_d[rf_wa_q] = 1'b0;
        end
        if (bus.alloc_valid && alloc_ok) begin
            pending_d[bus.alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            rr_ptr_q  <= PW'(NREQ - 1);
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
        end else begin
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_wb_sched
//  Description : Self-checking bench for reg_wb_sched: directed scenarios with
//                literal expectations plus randomized traffic compared every
//                cycle against a behavioural model of the scheduler rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_sched;
    import reg_wb_sched_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 6;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #10 clk = ~clk;

    reg_wb_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    reg_wb_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- behavioural model ----------------
    bit          m_pend [64];
    int          m_last;
    bit          m_we;
    int          m_wa;
    logic [31:0] m_wd;

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_last = NREQ - 1;
        m_we   = 1'b0;
        m_wa   = 0;
        m_wd   = '0;
    endtask

    function automatic logic [NREQ-1:0] model_grant(logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (v[idx]) return NREQ'(1) << idx;
        end
        return '0;
    endfunction

    function automatic bit model_hazard(int a);
        return m_pend[a] && !(m_we && m_wa == a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called in the low clock phase with inputs applied: compares, advances
    // the model, and returns at the next negedge.
    task automatic step();
        logic [NREQ-1:0] g;
        bit              aok;
        int              aa;
        #2;
        g   = model_grant(bus.req_valid);
        aa  = int'(bus.alloc_addr);
        aok = !m_pend[aa] || (m_we && m_wa == aa);
        chk("req_ready",   64'(bus.req_ready),   64'(g));
        chk("alloc_ready", 64'(bus.alloc_ready), 64'(aok));
        chk("hazard1",     64'(bus.hazard1),     64'(model_hazard(int'(bus.ra1))));
        chk("hazard2",     64'(bus.hazard2),     64'(model_hazard(int'(bus.ra2))));
        chk("rf_we",       64'(bus.rf_we),       64'(m_we));
        chk("rf_wa",       64'(bus.rf_wa),       64'(m_wa));
        chk("rf_wd",       64'(bus.rf_wd),       64'(m_wd));
        if (m_we) m_pend[m_wa] = 1'b0;
        if (bus.alloc_valid && aok) m_pend[aa] = 1'b1;
        m_we = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                m_we   = 1'b1;
                m_wa   = int'(bus.req_addr[i*AW +: AW]);
                m_wd   = bus.req_data[i*DW +: DW];
                m_last = i;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid   = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.alloc_valid = 1'b0;
        bus.alloc_addr  = '0;
        bus.ra1         = '0;
        bus.ra2         = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input int a, input logic [31:0] d);
        bus.req_valid[i]         = 1'b1;
        bus.req_addr[i*AW +: AW] = AW'(a);
        bus.req_data[i*DW +: DW] = d;
    endtask

    initial begin
        logic [NREQ-1:0] exp_g [6];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        idle_inputs();
        model_reset();
        #3;
        chk("reset rf_we", 64'(bus.rf_we), 64'd0);
        chk("reset rf_wa", 64'(bus.rf_wa), 64'd0);
        chk("reset rf_wd", 64'(bus.rf_wd), 64'd0);
        chk("reset req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single transfer, one-cycle write latency
        set_req(REQ_ALU, 5, 32'hDEADBEEF);
        #1 chk("t1 grant", 64'(bus.req_ready), 64'b001);
        step();
        idle_inputs();
        #1;
        chk("t1 rf_we", 64'(bus.rf_we), 64'd1);
        chk("t1 rf_wa", 64'(bus.rf_wa), 64'd5);
        chk("t1 rf_wd", 64'(bus.rf_wd), 64'hDEADBEEF);
        step();
        #1 chk("t1 rf_we off", 64'(bus.rf_we), 64'd0);

        // fairness with all requesters valid from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 10 + i, 32'h100 + 32'(i));
        for (int c = 0; c < 6; c++) begin
            #1 chk("rr grant", 64'(bus.req_ready), 64'(exp_g[c]));
            if (c > 0) chk("rr rf_wa", 64'(bus.rf_wa), 64'(10 + (c - 1) % 3));
            step();
        end
        idle_inputs();
        step();

        // allocate 12, hazard, load unit writes it back
        bus.alloc_valid = 1'b1; bus.alloc_addr = 6'd12;
        step();
        bus.alloc_valid = 1'b0; bus.ra1 = 6'd12;
        #1;
        chk("p12 hazard1", 64'(bus.hazard1), 64'd1);
        chk("p12 alloc_ready", 64'(bus.alloc_ready), 64'd0);
        set_req(REQ_LOAD, 12, 32'h0000_1212);
        step();
        bus.req_valid = '0;
        #1;
        chk("p12 hazard1 in write", 64'(bus.hazard1), 64'd0);
        step();
        #1 chk("p12 cleared", 64'(bus.alloc_ready), 64'd1);

        // allocate 7 on the edge that writes 7: set wins
        bus.alloc_valid = 1'b1; bus.alloc_addr = 6'd7;
        step();
        bus.alloc_valid = 1'b0;
        set_req(REQ_ALU, 7, 32'h77);
        step();
        bus.req_valid = '0;
        bus.alloc_valid = 1'b1;
        #1 chk("a7 alloc_ready", 64'(bus.alloc_ready), 64'd1);
        step();
        bus.alloc_valid = 1'b0; bus.ra2 = 6'd7;
        #1 chk("a7 hazard2", 64'(bus.hazard2), 64'd1);
        step();

        // both read ports on one pending register
        bus.alloc_valid = 1'b1; bus.alloc_addr = 6'd20;
        step();
        bus.alloc_valid = 1'b0; bus.ra1 = 6'd20; bus.ra2 = 6'd20;
        #1;
        chk("r20 hazard1", 64'(bus.hazard1), 64'd1);
        chk("r20 hazard2", 64'(bus.hazard2), 64'd1);
        bus.ra1 = 6'd21;
        #1 chk("r21 hazard1", 64'(bus.hazard1), 64'd0);
        step();

        // reset with pending bits and a write in flight
        bus.alloc_valid = 1'b1; bus.alloc_addr = 6'd3;
        step();
        bus.alloc_addr = 6'd9;
        step();
        bus.alloc_valid = 1'b0;
        set_req(REQ_FPU, 30, 32'hCAFE);
        step();
        bus.req_valid = '0; bus.ra1 = 6'd3; bus.ra2 = 6'd9;
        #1;
        chk("pre-rst rf_we", 64'(bus.rf_we), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst rf_we", 64'(bus.rf_we), 64'd0);
        chk("rst hazard1", 64'(bus.hazard1), 64'd0);
        chk("rst hazard2", 64'(bus.hazard2), 64'd0);
        model_reset();
        rst_n = 1'b1;
        bus.req_valid = 3'b111;
        #1 chk("rst next grant", 64'(bus.req_ready), 64'b001);
        step();

        // randomized traffic; small address range forces collisions
        for (int c = 0; c < 2000; c++) begin
            bus.req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
                bus.req_data[i*DW +: DW] = $urandom;
            end
            bus.alloc_valid = 1'($urandom);
            bus.alloc_addr  = AW'($urandom_range(0, 15));
            bus.ra1         = AW'($urandom_range(0, 15));
            bus.ra2         = AW'($urandom_range(0, 15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
